// File: rtl/beep_pkg.sv
// Note period constants, table geometry and FSM state encoding for the beep sequencer.
// Pure definitions: no latency, no backpressure.
package beep_pkg;

  localparam int TBL_N = 8;
  localparam int IDX_W = 3;
  localparam int TBL_W = 18;

  // period = 50 MHz / note frequency
  localparam logic [TBL_W-1:0] PER_C4 = 18'd190840;
  localparam logic [TBL_W-1:0] PER_D4 = 18'd170068;
  localparam logic [TBL_W-1:0] PER_E4 = 18'd151515;
  localparam logic [TBL_W-1:0] PER_F4 = 18'd143266;
  localparam logic [TBL_W-1:0] PER_G4 = 18'd127551;
  localparam logic [TBL_W-1:0] PER_A4 = 18'd113636;
  localparam logic [TBL_W-1:0] PER_B4 = 18'd101214;
  localparam logic [TBL_W-1:0] PER_C5 = 18'd95602;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  function automatic logic [TBL_W-1:0] note_period_of(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    return PER_C4;
      3'd1:    return PER_D4;
      3'd2:    return PER_E4;
      3'd3:    return PER_F4;
      3'd4:    return PER_G4;
      3'd5:    return PER_A4;
      3'd6:    return PER_B4;
      default: return PER_C5;
    endcase
  endfunction

endpackage

// File: rtl/beep_note_rom.sv
// Combinational note index -> PWM period lookup.
// Latency: 0 clocks; no backpressure.
module beep_note_rom
  import beep_pkg::*;
#(
  parameter int PER_W = 18
) (
  input  logic [IDX_W-1:0] idx,
  output logic [PER_W-1:0] period
);

  assign period = PER_W'(note_period_of(idx));

endmodule

// File: rtl/beep_note_seq.sv
// Melody sequencer: plays the note table with a silent gap per note, driving the PWM stage.
// Latency: start -> first note registered 1 clock later; no backpressure (stop aborts at once).
module beep_note_seq
  import beep_pkg::*;
#(
  parameter int NOTE_CYC  = 15_000_000,
  parameter int GAP_CYC   = 500_000,
  parameter int NUM_NOTES = 8,
  parameter int PER_W     = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  output logic [PER_W-1:0] note_period,
  output logic [PER_W-1:0] note_duty,
  output logic             note_vld,
  output logic             note_upd,
  output logic [2:0]       note_idx,
  output logic             busy,
  output logic             done
);

  // One counter serves both note and gap phases, so size it for the longer one.
  localparam int CYC_MAX = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
  localparam int CNT_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [2:0]       IDX_LAST  = 3'(NUM_NOTES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       next_idx;
  logic [PER_W-1:0] rom_period;
  logic             play_end;
  logic             gap_end;
  logic             seq_end;
  logic             last_note;
  logic             go_play;
  logic             go_gap;
  logic             go_idle;
  logic             go_done;

  always_comb begin
    play_end  = (state == ST_PLAY) && (cnt == NOTE_LAST);
    gap_end   = (state == ST_GAP) && (cnt == GAP_LAST);
    seq_end   = gap_end || (play_end && (GAP_CYC == 0));
    last_note = (note_idx == IDX_LAST);
    go_done   = !stop && seq_end && last_note && !loop_en;
    go_idle   = stop || go_done;
    go_play   = !stop && (((state == ST_IDLE) && start) ||
                          (seq_end && !(last_note && !loop_en)));
    go_gap    = !stop && play_end && (GAP_CYC != 0);
    next_idx  = ((state == ST_IDLE) || last_note) ? 3'd0 : note_idx + 3'd1;
  end

  // ROM is addressed with the index the next PLAY entry will use, so period lands with upd.
  beep_note_rom #(.PER_W(PER_W)) u_rom (
    .idx    (next_idx),
    .period (rom_period)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      note_period <= '0;
      note_duty   <= '0;
      note_vld    <= 1'b0;
      note_upd    <= 1'b0;
      note_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      note_upd <= go_play;
      done     <= go_done;
      if (go_idle) begin
        state       <= ST_IDLE;
        cnt         <= '0;
        note_vld    <= 1'b0;
        busy        <= 1'b0;
        note_idx    <= '0;
        note_period <= '0;
        note_duty   <= '0;
      end else if (go_play) begin
        state       <= ST_PLAY;
        cnt         <= '0;
        note_vld    <= 1'b1;
        busy        <= 1'b1;
        note_idx    <= next_idx;
        note_period <= rom_period;
        note_duty   <= rom_period >> 1;
      end else if (go_gap) begin
        state    <= ST_GAP;
        cnt      <= '0;
        note_vld <= 1'b0;
      end else if (state != ST_IDLE) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_beep_note_seq.sv
// Bench for beep_note_seq: NOTE_CYC=10, GAP_CYC=2 instance plus a GAP_CYC=0 instance.
module tb_beep_note_seq;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop_en, start0, stop0;
  logic [17:0] period, duty, period0, duty0;
  logic        vld, upd, busy, done, vld0, upd0, busy0, done0;
  logic [2:0]  idx, idx0;

  int n_chk = 0, n_pass = 0, done_cnt = 0, done0_cnt = 0;

  typedef struct {logic [2:0] idx; logic [17:0] per;} note_t;
  typedef struct {int cyc; logic vld; logic upd; logic busy; logic done; logic [2:0] idx; logic [17:0] per;} vec_t;

  note_t       sb[$];
  note_t       sb0[$];
  logic [17:0] exp_per [8];
  vec_t        tbl [10];

  always #5 clk = ~clk;

  beep_note_seq #(.NOTE_CYC(10), .GAP_CYC(2), .NUM_NOTES(8), .PER_W(18)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .note_period(period), .note_duty(duty), .note_vld(vld), .note_upd(upd),
    .note_idx(idx), .busy(busy), .done(done)
  );

  beep_note_seq #(.NOTE_CYC(10), .GAP_CYC(0), .NUM_NOTES(8), .PER_W(18)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .stop(stop0), .loop_en(loop_en),
    .note_period(period0), .note_duty(duty0), .note_vld(vld0), .note_upd(upd0),
    .note_idx(idx0), .busy(busy0), .done(done0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input bit to_gap0, input int first, input int count);
    note_t e;
    for (int i = 0; i < count; i++) begin
      e.idx = 3'((first + i) % 8);
      e.per = exp_per[(first + i) % 8];
      if (to_gap0) sb0.push_back(e);
      else sb.push_back(e);
    end
  endtask

  // Scoreboards: every upd strobe must match the next expected note.
  always @(posedge clk) begin
    #1;
    if (done) done_cnt++;
    if (upd) begin
      if (sb.size() == 0) chk("upd_unexpected", 32'(upd), 32'd0);
      else begin
        note_t e;
        e = sb.pop_front();
        chk("sb_idx", 32'(idx), 32'(e.idx));
        chk("sb_period", 32'(period), 32'(e.per));
        chk("sb_duty", 32'(duty), 32'(e.per >> 1));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (done0) done0_cnt++;
    if (upd0) begin
      if (sb0.size() == 0) chk("gap0_upd_unexpected", 32'(upd0), 32'd0);
      else begin
        note_t e;
        e = sb0.pop_front();
        chk("gap0_sb_idx", 32'(idx0), 32'(e.idx));
        chk("gap0_sb_period", 32'(period0), 32'(e.per));
      end
    end
  end

  initial begin
    int vi, d0, c;
    exp_per = '{18'd190840, 18'd170068, 18'd151515, 18'd143266,
                18'd127551, 18'd113636, 18'd101214, 18'd95602};
    //            cyc  vld   upd   busy  done  idx   period
    tbl[0] = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 18'd190840};
    tbl[1] = '{2,  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 18'd190840};
    tbl[2] = '{10, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 18'd190840};
    tbl[3] = '{11, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 18'd190840};
    tbl[4] = '{12, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 18'd190840};
    tbl[5] = '{13, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 18'd170068};
    tbl[6] = '{85, 1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 18'd95602};
    tbl[7] = '{96, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 18'd95602};
    tbl[8] = '{97, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 18'd0};
    tbl[9] = '{98, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 18'd0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; start0 = 1'b0; stop0 = 1'b0;
    step(3);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_upd", 32'(upd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_duty", 32'(duty), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_busy_gap0", 32'(busy0), 32'd0);
    rst = 1'b0;
    step(2);

    // Full melody, no loop: table-driven cycle checks after the start pulse.
    d0 = done_cnt;
    push(1'b0, 0, 8);
    start = 1'b1; step(1); start = 1'b0;
    vi = 0;
    for (int cy = 1; cy <= 98; cy++) begin
      if (cy > 1) step(1);
      if (vi < 10 && tbl[vi].cyc == cy) begin
        chk($sformatf("run_c%0d_vld", cy), 32'(vld), 32'(tbl[vi].vld));
        chk($sformatf("run_c%0d_upd", cy), 32'(upd), 32'(tbl[vi].upd));
        chk($sformatf("run_c%0d_busy", cy), 32'(busy), 32'(tbl[vi].busy));
        chk($sformatf("run_c%0d_done", cy), 32'(done), 32'(tbl[vi].done));
        chk($sformatf("run_c%0d_idx", cy), 32'(idx), 32'(tbl[vi].idx));
        chk($sformatf("run_c%0d_period", cy), 32'(period), 32'(tbl[vi].per));
        chk($sformatf("run_c%0d_duty", cy), 32'(duty), 32'(tbl[vi].per >> 1));
        vi++;
      end
    end
    step(2);
    chk("run_done_count", 32'(done_cnt - d0), 32'd1);
    chk("run_sb_drained", 32'(sb.size()), 32'd0);

    // Looping: wraps to note 0 after note 7's gap, no done, runs until stop.
    d0 = done_cnt;
    loop_en = 1'b1;
    push(1'b0, 0, 9);
    start = 1'b1; step(1); start = 1'b0; c = 1;
    step(97 - c); c = 97;
    chk("loop_wrap_upd", 32'(upd), 32'd1);
    chk("loop_wrap_idx", 32'(idx), 32'd0);
    chk("loop_wrap_period", 32'(period), 32'd190840);
    chk("loop_wrap_busy", 32'(busy), 32'd1);
    chk("loop_wrap_done", 32'(done), 32'd0);
    step(2);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("loop_stop_vld", 32'(vld), 32'd0);
    chk("loop_stop_busy", 32'(busy), 32'd0);
    chk("loop_stop_period", 32'(period), 32'd0);
    loop_en = 1'b0;
    step(3);
    chk("loop_no_done", 32'(done_cnt - d0), 32'd0);
    chk("loop_sb_drained", 32'(sb.size()), 32'd0);

    // Stop on the 5th clock of note 3.
    d0 = done_cnt;
    push(1'b0, 0, 4);
    start = 1'b1; step(1); start = 1'b0; c = 1;
    step(41 - c);
    chk("stop_pre_idx", 32'(idx), 32'd3);
    chk("stop_pre_vld", 32'(vld), 32'd1);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("stop_vld", 32'(vld), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_upd", 32'(upd), 32'd0);
    chk("stop_period", 32'(period), 32'd0);
    step(30);
    chk("stop_stays_idle", 32'(busy), 32'd0);
    chk("stop_no_done", 32'(done_cnt - d0), 32'd0);
    chk("stop_sb_drained", 32'(sb.size()), 32'd0);

    // start and stop together: stop wins.
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 32'(busy), 32'd0);
    chk("startstop_vld", 32'(vld), 32'd0);
    step(3);
    chk("startstop_still_idle", 32'(busy), 32'd0);

    // start while busy is ignored.
    push(1'b0, 0, 2);
    start = 1'b1; step(1); start = 1'b0; c = 1;
    step(5 - c); c = 5;
    start = 1'b1; step(1); start = 1'b0; c = 6;
    chk("rebusy_idx", 32'(idx), 32'd0);
    chk("rebusy_upd", 32'(upd), 32'd0);
    chk("rebusy_vld", 32'(vld), 32'd1);
    step(13 - c);
    chk("rebusy_next_idx", 32'(idx), 32'd1);
    chk("rebusy_next_upd", 32'(upd), 32'd1);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("rebusy_stop_busy", 32'(busy), 32'd0);
    step(2);
    chk("rebusy_sb_drained", 32'(sb.size()), 32'd0);

    // Reset mid-melody behaves like power-on reset, then a fresh start works.
    push(1'b0, 0, 2);
    start = 1'b1; step(1); start = 1'b0;
    step(19);
    rst = 1'b1; step(1);
    chk("midrst_vld", 32'(vld), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_period", 32'(period), 32'd0);
    chk("midrst_idx", 32'(idx), 32'd0);
    rst = 1'b0;
    step(1);
    sb.delete();
    push(1'b0, 0, 1);
    start = 1'b1; step(1); start = 1'b0;
    chk("midrst_restart_upd", 32'(upd), 32'd1);
    chk("midrst_restart_period", 32'(period), 32'd190840);
    stop = 1'b1; step(1); stop = 1'b0;
    step(2);

    // GAP_CYC=0 instance: vld continuously high, upd every 10 clocks.
    d0 = done0_cnt;
    push(1'b1, 0, 8);
    start0 = 1'b1; step(1); start0 = 1'b0;
    for (int cy = 1; cy <= 80; cy++) begin
      if (cy > 1) step(1);
      chk($sformatf("gap0_c%0d_vld", cy), 32'(vld0), 32'd1);
      chk($sformatf("gap0_c%0d_upd", cy), 32'(upd0), ((cy - 1) % 10 == 0) ? 32'd1 : 32'd0);
    end
    step(1);
    chk("gap0_done", 32'(done0), 32'd1);
    chk("gap0_busy_end", 32'(busy0), 32'd0);
    chk("gap0_vld_end", 32'(vld0), 32'd0);
    step(2);
    chk("gap0_done_count", 32'(done0_cnt - d0), 32'd1);
    chk("gap0_sb_drained", 32'(sb0.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
